// File: rtl/uart_wb_master.sv
// uart_wb_master: byte-stream command decoder that issues single Wishbone
// master cycles and returns the outcome as response bytes.
//
// Commands (multi-byte fields MSB first):
//   'W' a3 a2 a1 a0 d3 d2 d1 d0 -> write cycle -> 'K'
//   'R' a3 a2 a1 a0             -> read cycle  -> d3 d2 d1 d0
//   anything else               -> '?'
//   bus timeout                 -> 'T' only
//
// Tx handshake: a byte is transferred on a clock edge where o_tx_valid and
// i_tx_ready are both high; o_tx_valid drops on the following edge, and
// o_tx_data stays put until i_tx_ready has gone low and come back high (the
// transmitter reads the data throughout its frame). Only then is the next
// byte offered. The rx side has no back-pressure: i_rx_valid is a one-cycle
// pulse, and bytes that arrive while a bus cycle or response is in progress
// are dropped.
module uart_wb_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        cycle,
  output logic        strobe,
  output logic        write_enable,
  output logic [31:0] address,
  output logic [31:0] data_in,
  input  logic [31:0] data_out,
  input  logic        ack,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_error,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic [2:0]  state_dbg
);

  localparam logic [7:0]  CMD_W    = 8'h57;
  localparam logic [7:0]  CMD_R    = 8'h52;
  localparam logic [7:0]  RSP_OK   = 8'h4B;
  localparam logic [7:0]  RSP_BAD  = 8'h3F;
  localparam logic [7:0]  RSP_TMO  = 8'h54;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  // The response phase is split into three sub-states: offering a byte,
  // waiting for the transmitter to go busy, and waiting for it to go idle.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_DATA      = 3'd2,
    S_BUS       = 3'd3,
    S_RESP_SEND = 3'd4,
    S_RESP_LOW  = 3'd5,
    S_RESP_HIGH = 3'd6
  } state_t;

  state_t      state, state_next;
  logic        op_write;
  logic [1:0]  byte_cnt;
  logic [1:0]  resp_left;
  logic [15:0] tmo_cnt;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        rx_byte;
  logic        is_cmd;

  assign rx_byte = i_rx_valid && !i_rx_error;
  assign is_cmd  = (i_rx_data == CMD_W) || (i_rx_data == CMD_R);

  // Bus signals follow the state register directly, so a reset drops them
  // immediately without waiting for a clock edge.
  assign cycle        = (state == S_BUS);
  assign strobe       = (state == S_BUS);
  assign write_enable = (state == S_BUS) && op_write;
  assign address      = addr_reg;
  assign data_in      = wdata_reg;
  assign state_dbg    = state;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (rx_byte) state_next = is_cmd ? S_ADDR : S_RESP_SEND;
      end
      S_ADDR: begin
        if (i_rx_error) state_next = S_IDLE;
        else if (i_rx_valid && byte_cnt == 2'd3) state_next = op_write ? S_DATA : S_BUS;
      end
      S_DATA: begin
        if (i_rx_error) state_next = S_IDLE;
        else if (i_rx_valid && byte_cnt == 2'd3) state_next = S_BUS;
      end
      S_BUS: begin
        if (ack || tmo_cnt == TMO_LAST) state_next = S_RESP_SEND;
      end
      S_RESP_SEND: begin
        if (i_tx_ready) state_next = S_RESP_LOW;
      end
      S_RESP_LOW: begin
        if (!i_tx_ready) state_next = S_RESP_HIGH;
      end
      S_RESP_HIGH: begin
        if (i_tx_ready) state_next = (resp_left == 2'd0) ? S_IDLE : S_RESP_SEND;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command capture, bus timeout counting and response byte sequencing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_write   <= 1'b0;
      byte_cnt   <= 2'd0;
      resp_left  <= 2'd0;
      tmo_cnt    <= 16'd0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      rdata_reg  <= 32'd0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h00;
    end else begin
      if (state != S_BUS) tmo_cnt <= 16'd0;
      case (state)
        S_IDLE: begin
          if (rx_byte) begin
            if (is_cmd) begin
              op_write <= (i_rx_data == CMD_W);
              byte_cnt <= 2'd0;
            end else begin
              o_tx_data  <= RSP_BAD;
              o_tx_valid <= 1'b1;
              resp_left  <= 2'd0;
            end
          end
        end
        S_ADDR: begin
          if (rx_byte) begin
            addr_reg <= {addr_reg[23:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (rx_byte) begin
            wdata_reg <= {wdata_reg[23:0], i_rx_data};
            byte_cnt  <= byte_cnt + 2'd1;
          end
        end
        S_BUS: begin
          if (ack) begin
            rdata_reg  <= data_out;
            o_tx_valid <= 1'b1;
            if (op_write) begin
              o_tx_data <= RSP_OK;
              resp_left <= 2'd0;
            end else begin
              o_tx_data <= data_out[31:24];
              resp_left <= 2'd3;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            o_tx_data  <= RSP_TMO;
            o_tx_valid <= 1'b1;
            resp_left  <= 2'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_RESP_SEND: begin
          if (i_tx_ready) o_tx_valid <= 1'b0;
        end
        S_RESP_HIGH: begin
          // Next read byte: the register shifts so byte 2 is always next.
          if (i_tx_ready && resp_left != 2'd0) begin
            o_tx_data  <= rdata_reg[23:16];
            rdata_reg  <= {rdata_reg[23:0], 8'h00};
            resp_left  <= resp_left - 2'd1;
            o_tx_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
